// File: rtl/lcd_write_sequencer.sv
// Write-only HD44780-style LCD sequencer: power-up delay, fixed init table, then
// round-robin service of two byte requesters, all timed by cycle counters on clk.
module lcd_write_sequencer #(
    parameter int unsigned POWERUP_CYC = 2_000_000,
    parameter int unsigned SETUP_CYC   = 10,
    parameter int unsigned EN_CYC      = 50,
    parameter int unsigned HOLD_CYC    = 10,
    parameter int unsigned EXEC_CYC    = 5_000,
    parameter int unsigned CLEAR_CYC   = 200_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic       a_rs,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_rs,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] dout,
    output logic       init_done,
    output logic       busy
);
    typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

    localparam logic [31:0] PWRUP_LAST = POWERUP_CYC - 1;
    localparam logic [31:0] SETUP_LAST = SETUP_CYC - 1;
    localparam logic [31:0] EN_LAST    = EN_CYC - 1;
    localparam logic [31:0] HOLD_LAST  = HOLD_CYC - 1;
    localparam logic [31:0] EXEC_LAST  = EXEC_CYC - 1;
    localparam logic [31:0] CLEAR_LAST = CLEAR_CYC - 1;
    localparam logic [2:0]  INIT_LAST  = 3'd4;

    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  init_idx;
    logic        last_b;
    logic        grant_a;
    logic        grant_b;
    logic        can_accept;
    logic [31:0] wait_last;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h01;
            3'd2:    init_byte = 8'h0E;
            3'd3:    init_byte = 8'h06;
            default: init_byte = 8'h80;
        endcase
    endfunction

    // Ties go to whichever requester was not served last.
    assign grant_a    = a_valid & (~b_valid | last_b);
    assign grant_b    = b_valid & (~a_valid | ~last_b);
    assign can_accept = (state == IDLE) & init_done;
    assign a_ready    = can_accept & grant_a;
    assign b_ready    = can_accept & grant_b;

    assign rw   = 1'b0;
    assign busy = (state != IDLE);

    // Clear/home commands need the long execution wait.
    assign wait_last = (~rs & ((dout == 8'h01) | (dout == 8'h02))) ? CLEAR_LAST : EXEC_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWRUP;
            cnt       <= '0;
            init_idx  <= '0;
            last_b    <= 1'b1;
            rs        <= 1'b0;
            dout      <= 8'h00;
            en        <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                PWRUP: begin
                    if (cnt == PWRUP_LAST) begin
                        cnt      <= '0;
                        init_idx <= '0;
                        rs       <= 1'b0;
                        dout     <= init_byte(3'd0);
                        state    <= SETUP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        en    <= 1'b1;
                        state <= PULSE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                PULSE: begin
                    if (cnt == EN_LAST) begin
                        cnt   <= '0;
                        en    <= 1'b0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (init_done) begin
                            state <= IDLE;
                        end else if (init_idx == INIT_LAST) begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                            rs       <= 1'b0;
                            dout     <= init_byte(init_idx + 3'd1);
                            state    <= SETUP;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                IDLE: begin
                    cnt <= '0;
                    if (a_ready) begin
                        rs     <= a_rs;
                        dout   <= a_data;
                        last_b <= 1'b0;
                        state  <= SETUP;
                    end else if (b_ready) begin
                        rs     <= b_rs;
                        dout   <= b_data;
                        last_b <= 1'b1;
                        state  <= SETUP;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: a timeline model predicts every output each cycle
// from the write schedule (load edge, setup/pulse/hold/wait lengths) and compares.
module tb_lcd_write_sequencer;
    localparam int P = 20, S = 2, E = 3, H = 2, X = 5, C = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, a_rs = 1'b0, b_valid = 1'b0, b_rs = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_ready, b_ready, rs, rw, en, init_done, busy;
    logic [7:0] dout;
    logic [14:0] obs, exp_vec;

    int checks = 0, errors = 0, cyc = 0;
    int  wq_load[$];
    logic [8:0] wq_byte[$];
    int  m_free, m_init_end;
    bit  m_last_b, a_acc, b_acc;
    logic [7:0] init_tab [5] = '{8'h38, 8'h01, 8'h0E, 8'h06, 8'h80};

    lcd_write_sequencer #(
        .POWERUP_CYC(P), .SETUP_CYC(S), .EN_CYC(E),
        .HOLD_CYC(H), .EXEC_CYC(X), .CLEAR_CYC(C)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_rs(a_rs), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rs(b_rs), .b_data(b_data), .b_ready(b_ready),
        .rs(rs), .rw(rw), .en(en), .dout(dout),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Edge count since reset release: posedge k is the k-th edge after release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    assign obs = {en, rs, dout, a_ready, b_ready, busy, init_done, rw};

    function automatic int wait_for(input logic [8:0] wb);
        return (!wb[8] && (wb[7:0] == 8'h01 || wb[7:0] == 8'h02)) ? C : X;
    endfunction

    // Write schedule after reset release: each init entry loads, then takes S+E+H+wait.
    task automatic model_init();
        int load;
        wq_load.delete();
        wq_byte.delete();
        load = P;
        for (int i = 0; i < 5; i++) begin
            wq_load.push_back(load);
            wq_byte.push_back({1'b0, init_tab[i]});
            load += S + E + H + wait_for({1'b0, init_tab[i]});
        end
        m_init_end = load;
        m_free     = load;
        m_last_b   = 1'b1;
    endtask

    task automatic model_eval();
        int k;
        bit idle, ea, eb, e;
        logic [8:0] cur, nb;
        k    = cyc;
        idle = (k >= m_free);
        ea   = idle && a_valid && (!b_valid || m_last_b);
        eb   = idle && b_valid && (!a_valid || !m_last_b);
        cur  = 9'h000;
        e    = 1'b0;
        foreach (wq_load[i]) begin
            if (wq_load[i] <= k) cur = wq_byte[i];
            if (k >= wq_load[i] + S && k < wq_load[i] + S + E) e = 1'b1;
        end
        exp_vec = {e, cur[8], cur[7:0], ea, eb, !idle, (k >= m_init_end), 1'b0};
        if (ea || eb) begin
            nb = ea ? {a_rs, a_data} : {b_rs, b_data};
            wq_load.push_back(k + 1);
            wq_byte.push_back(nb);
            m_free   = k + 1 + S + E + H + wait_for(nb);
            m_last_b = eb;
        end
    endtask

    // Requester behaviour: hold until accepted, then maybe offer a new byte.
    task automatic drive_reqs(input int pa, input int pb, input int rs_mode, input int wd);
        if (a_acc || !a_valid) begin
            a_valid = ($urandom_range(99) < pa);
            a_rs    = (rs_mode == 2) ? 1'($urandom_range(1)) : 1'(rs_mode);
            a_data  = 8'($urandom);
        end else if ($urandom_range(99) < wd) a_valid = 1'b0;
        if (b_acc || !b_valid) begin
            b_valid = ($urandom_range(99) < pb);
            b_rs    = (rs_mode == 2) ? 1'($urandom_range(1)) : 1'(rs_mode);
            b_data  = 8'($urandom);
        end else if ($urandom_range(99) < wd) b_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 15'h0004) begin
                errors++;
                $display("FAIL reset_values obs=%h exp=%h", obs, 15'h0004);
            end
        end
    endtask

    // a_valid held through power-up and init; it must wait for init_done.
    task automatic test_init_pending_a();
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'($urandom); b_valid = 1'b0;
        a_acc = 1'b0; b_acc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_init();
        for (int i = 0; i < m_init_end + S + E + H + X + 4; i++) begin
            @(negedge clk);
            if (a_acc) a_valid = 1'b0;
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL init_seq cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
            end
            a_acc = a_valid && a_ready;
        end
    endtask

    task automatic test_single_a();
        @(negedge clk);
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h48; a_acc = 1'b0;
        #1;
        for (int i = 0; i < 18; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (a_acc) a_valid = 1'b0;
                #1;
            end
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL single_a cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
            end
            a_acc = a_valid && a_ready;
        end
    endtask

    task automatic test_clear_cmd();
        logic [7:0] cmds [2] = '{8'h01, 8'h0C};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            b_valid = 1'b1; b_rs = 1'b0; b_data = cmds[c]; b_acc = 1'b0;
            #1;
            for (int i = 0; i < 24; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    if (b_acc) b_valid = 1'b0;
                    #1;
                end
                model_eval();
                checks++;
                if (obs !== exp_vec) begin
                    errors++;
                    $display("FAIL clear_cmd_%h cyc=%0d obs=%h exp=%h", cmds[c], cyc, obs, exp_vec);
                end
                b_acc = b_valid && b_ready;
            end
        end
    endtask

    task automatic test_back_to_back();
        a_acc = 1'b0; b_acc = 1'b0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            drive_reqs(100, 100, 1, 0);
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
            end
            a_acc = a_valid && a_ready;
            b_acc = b_valid && b_ready;
        end
    endtask

    task automatic test_random();
        a_acc = 1'b0; b_acc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            drive_reqs(40, 40, 2, 10);
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
            end
            a_acc = a_valid && a_ready;
            b_acc = b_valid && b_ready;
        end
    endtask

    // Reset mid-pulse: en drops at once, init reruns, the lost byte never reappears.
    task automatic test_reset_mid_write();
        bit hit = 1'b0;
        int rs_pulses = 0;
        @(negedge clk);
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'($urandom); b_valid = 1'b0; a_acc = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (i > 0) @(negedge clk);
            if (a_acc) a_valid = 1'b0;
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
            end
            a_acc = a_valid && a_ready;
            hit = exp_vec[14] && !a_valid;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_target_pulse obs=none exp=en_high_client_write");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 15'h0004) begin
            errors++;
            $display("FAIL async_reset obs=%h exp=%h", obs, 15'h0004);
        end
        a_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_init();
        for (int i = 0; i < m_init_end + 15; i++) begin
            @(negedge clk);
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL reinit cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
            end
            if (en && rs) rs_pulses++;
        end
        checks++;
        if (rs_pulses != 0) begin
            errors++;
            $display("FAIL lost_byte_replayed obs=%0d exp=0", rs_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_init_pending_a();
        test_single_a();
        test_clear_cmd();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
